cam_capture_rgb444: RTL and testbench

Pixel capture stage between the OV7670 camera parallel bus and the dual-port frame buffer. It frames the camera stream with VSYNC/HREF and packs each RGB565 byte pair into one RGB444 word. It writes that word to sequential buffer addresses, row-major, for a 160x120 (QQVGA) image. The VGA side reads the same buffer at address posX + posY*160.

---
 rtl/cam_capture_rgb444_if.sv | 27 ++
 rtl/cam_capture_rgb444.sv | 118 +++++++++++
 tb/tb_cam_capture_rgb444.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/cam_capture_rgb444_if.sv
// Camera-to-frame-buffer capture bus.
// Camera side : CAM_px_data, CAM_href, CAM_vsync (driven by the camera/master)
// Buffer side : DP_RAM_regW, DP_RAM_addr_in, DP_RAM_data_in (driven by the capture block/slave)
// Status      : frame_done, overflow (driven by the capture block/slave)
interface cam_capture_rgb444_if #(
   parameter int unsigned AW = 15,
   parameter int unsigned DW = 12
);
   logic [7:0]    CAM_px_data;
   logic          CAM_href;
   logic          CAM_vsync;
   logic          DP_RAM_regW;
   logic [AW-1:0] DP_RAM_addr_in;
   logic [DW-1:0] DP_RAM_data_in;
   logic          frame_done;
   logic          overflow;

   modport master (
      output CAM_px_data, CAM_href, CAM_vsync,
      input  DP_RAM_regW, DP_RAM_addr_in, DP_RAM_data_in, frame_done, overflow
   );

   modport slave (
      input  CAM_px_data, CAM_href, CAM_vsync,
      output DP_RAM_regW, DP_RAM_addr_in, DP_RAM_data_in, frame_done, overflow
   );
endinterface

// File: rtl/cam_capture_rgb444.sv
// OV7670 pixel capture: frames the byte stream with VSYNC/HREF, packs each
// RGB565 byte pair into an RGB444 word and writes it row-major to the frame
// buffer, one address per pixel, for a CAM_SCREEN_X x CAM_SCREEN_Y image.
// Ports:
//   CAM_pclk : pixel clock, all logic on its rising edge
//   rst      : synchronous active-low reset
//   bus      : camera inputs, buffer write port and frame status (slave side)
module cam_capture_rgb444 #(
   parameter int unsigned AW           = 15,
   parameter int unsigned DW           = 12,
   parameter int unsigned CAM_SCREEN_X = 160,
   parameter int unsigned CAM_SCREEN_Y = 120
) (
   input  logic                 CAM_pclk,
   input  logic                 rst,
   cam_capture_rgb444_if.slave  bus
);
   localparam int unsigned NPIX = CAM_SCREEN_X * CAM_SCREEN_Y;

   typedef enum logic [1:0] {IDLE, BYTE1, BYTE2, WAIT_LOW} state_t;

   state_t        state, state_nxt;
   logic          vsync_d;
   logic [AW-1:0] pix_cnt, pix_cnt_nxt;
   logic [7:0]    byte1, byte1_nxt;
   logic          regw, regw_nxt;
   logic [AW-1:0] addr, addr_nxt;
   logic [DW-1:0] data, data_nxt;
   logic          frame_done, frame_done_nxt;
   logic          overflow, overflow_nxt;

   logic vs_fall_c, vs_rise_c;
   assign vs_fall_c = vsync_d & ~bus.CAM_vsync;
   assign vs_rise_c = ~vsync_d & bus.CAM_vsync;

   // Next-state and registered-output logic; vsync outranks href everywhere
   always_comb begin
      state_nxt      = state;
      pix_cnt_nxt    = pix_cnt;
      byte1_nxt      = byte1;
      regw_nxt       = 1'b0;
      addr_nxt       = addr;
      data_nxt       = data;
      frame_done_nxt = 1'b0;
      overflow_nxt   = overflow;

      case (state)
         IDLE, WAIT_LOW: begin
            if (vs_fall_c) begin
               pix_cnt_nxt  = '0;
               overflow_nxt = 1'b0;
               state_nxt    = BYTE1;
            end
         end
         BYTE1: begin
            if (bus.CAM_vsync) begin
               frame_done_nxt = vs_rise_c && (pix_cnt != '0);
               state_nxt      = WAIT_LOW;
            end else if (bus.CAM_href) begin
               byte1_nxt = bus.CAM_px_data;
               state_nxt = BYTE2;
            end
         end
         BYTE2: begin
            if (bus.CAM_vsync) begin
               frame_done_nxt = vs_rise_c && (pix_cnt != '0);
               state_nxt      = WAIT_LOW;
            end else begin
               // href low here means an odd byte count: byte1 is dropped
               state_nxt = BYTE1;
               if (bus.CAM_href) begin
                  if (pix_cnt == AW'(NPIX)) begin
                     overflow_nxt = 1'b1;
                  end else begin
                     regw_nxt    = 1'b1;
                     addr_nxt    = pix_cnt;
                     data_nxt    = DW'({byte1[7:4], byte1[2:0], bus.CAM_px_data[7],
                                        bus.CAM_px_data[4:1]});
                     pix_cnt_nxt = pix_cnt + AW'(1);
                  end
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge CAM_pclk) begin
      if (!rst) begin
         state      <= IDLE;
         vsync_d    <= 1'b0;
         pix_cnt    <= '0;
         byte1      <= '0;
         regw       <= 1'b0;
         addr       <= '0;
         data       <= '0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         state      <= state_nxt;
         vsync_d    <= bus.CAM_vsync;
         pix_cnt    <= pix_cnt_nxt;
         byte1      <= byte1_nxt;
         regw       <= regw_nxt;
         addr       <= addr_nxt;
         data       <= data_nxt;
         frame_done <= frame_done_nxt;
         overflow   <= overflow_nxt;
      end
   end

   assign bus.DP_RAM_regW    = regw;
   assign bus.DP_RAM_addr_in = addr;
   assign bus.DP_RAM_data_in = data;
   assign bus.frame_done     = frame_done;
   assign bus.overflow       = overflow;
endmodule

// File: tb/tb_cam_capture_rgb444.sv
// Directed bench for cam_capture_rgb444: reset, conversion, latency, odd
// lines, full frame, overflow and mid-frame aborts. Buffer writes are
// scoreboarded against expected (address, pixel) pairs.
module tb_cam_capture_rgb444;
   localparam int unsigned AW   = 15;
   localparam int unsigned DW   = 12;
   localparam int unsigned XS   = 160;
   localparam int unsigned YS   = 120;
   localparam int unsigned NPIX = XS * YS;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   cam_capture_rgb444_if #(.AW(AW), .DW(DW)) bus ();

   cam_capture_rgb444 #(
      .AW(AW), .DW(DW), .CAM_SCREEN_X(XS), .CAM_SCREEN_Y(YS)
   ) dut (
      .CAM_pclk (clk),
      .rst      (rst),
      .bus      (bus)
   );

   int  checks = 0;
   int  errors = 0;
   int  wr_cnt = 0;
   int  fd_cnt = 0;
   int  m_cnt  = 0;
   wr_t exp_q[$];
   wr_t e;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Write monitor: every regW must match the next expected write
   always @(negedge clk) begin
      if (bus.frame_done) fd_cnt++;
      if (bus.DP_RAM_regW) begin
         wr_cnt++;
         if (exp_q.size() == 0) begin
            chk("unexp_wr", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 32'(bus.DP_RAM_addr_in), 32'(e.addr));
            chk("wr_data", 32'(bus.DP_RAM_data_in), 32'(e.data));
         end
      end
   end

   task automatic cyc(input logic vs, input logic hr, input logic [7:0] d);
      @(posedge clk);
      #1;
      bus.CAM_vsync   = vs;
      bus.CAM_href    = hr;
      bus.CAM_px_data = d;
   endtask

   task automatic push_exp(input logic [DW-1:0] px);
      if (m_cnt < int'(NPIX)) begin
         exp_q.push_back({AW'(m_cnt), px});
         m_cnt++;
      end
   endtask

   task automatic frame_start();
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 8'h00);
      m_cnt = 0;
   endtask

   task automatic frame_end();
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h00);
   endtask

   // Pixel with random junk in the bits the 565->444 truncation drops
   task automatic send_pat(input int idx);
      logic [11:0] px;
      logic [31:0] junk;
      px   = 12'((idx * 7 + 3) & 32'hFFF);
      junk = $urandom;
      push_exp(px);
      cyc(1'b0, 1'b1, {px[11:8], junk[0], px[7:5]});
      cyc(1'b0, 1'b1, {px[4], junk[2:1], px[3:0], junk[3]});
   endtask

   task automatic send_lines(input int lines);
      for (int l = 0; l < lines; l++) begin
         for (int p = 0; p < int'(XS); p++) send_pat(l * int'(XS) + p);
         cyc(1'b0, 1'b0, 8'h00);
      end
   endtask

   int fd0, w0;

   initial begin
      bus.CAM_vsync = 1'b0;
      bus.CAM_href = 1'b0;
      bus.CAM_px_data = 8'h00;

      // Reset with random bus activity
      for (int i = 0; i < 3; i++) begin
         cyc(1'($urandom), 1'($urandom), 8'($urandom));
         chk("rst_regw", 32'(bus.DP_RAM_regW), 32'd0);
      end
      chk("rst_addr", 32'(bus.DP_RAM_addr_in), 32'd0);
      chk("rst_data", 32'(bus.DP_RAM_data_in), 32'd0);
      chk("rst_fd", 32'(bus.frame_done), 32'd0);
      chk("rst_ovf", 32'(bus.overflow), 32'd0);
      cyc(1'b0, 1'b0, 8'h00);
      rst = 1'b1;
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 8'($urandom));
      cyc(1'b0, 1'b0, 8'h00);
      chk("no_vs_fall_wr", 32'(wr_cnt), 32'd0);

      // Conversion and latency
      fd0 = fd_cnt;
      frame_start();
      push_exp(12'hF0F);
      cyc(1'b0, 1'b1, 8'hF8);
      cyc(1'b0, 1'b1, 8'h1F);
      cyc(1'b0, 1'b1, 8'h07);
      chk("lat_rw_hi", 32'(bus.DP_RAM_regW), 32'd1);
      push_exp(12'h0F0);
      cyc(1'b0, 1'b1, 8'hE0);
      chk("lat_rw_lo", 32'(bus.DP_RAM_regW), 32'd0);
      cyc(1'b0, 1'b0, 8'h00);
      chk("rw2_hi", 32'(bus.DP_RAM_regW), 32'd1);
      cyc(1'b0, 1'b0, 8'h00);
      chk("rw2_lo", 32'(bus.DP_RAM_regW), 32'd0);
      chk("hold_addr", 32'(bus.DP_RAM_addr_in), 32'd1);
      chk("hold_data", 32'(bus.DP_RAM_data_in), 32'h0F0);
      frame_end();
      chk("conv_fd", 32'(fd_cnt - fd0), 32'd1);
      chk("conv_wr", 32'(wr_cnt), 32'd2);

      // Odd-length line: third byte dropped, next line continues at addr 1
      w0 = wr_cnt;
      frame_start();
      push_exp(12'h00F);
      cyc(1'b0, 1'b1, 8'h00);
      cyc(1'b0, 1'b1, 8'h1F);
      cyc(1'b0, 1'b1, 8'hAA);
      cyc(1'b0, 1'b0, 8'h00);
      push_exp(12'h14A);
      cyc(1'b0, 1'b1, 8'h12);
      cyc(1'b0, 1'b1, 8'h34);
      cyc(1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 8'h00);
      chk("odd_wr", 32'(wr_cnt - w0), 32'd2);
      chk("odd_addr", 32'(bus.DP_RAM_addr_in), 32'd1);
      frame_end();

      // Abort by vsync at pixel 500
      fd0 = fd_cnt;
      w0  = wr_cnt;
      frame_start();
      for (int i = 0; i < 500; i++) send_pat(i);
      frame_end();
      chk("vs_abort_fd", 32'(fd_cnt - fd0), 32'd1);
      chk("vs_abort_wr", 32'(wr_cnt - w0), 32'd500);
      frame_start();
      send_pat(7);
      cyc(1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 8'h00);
      chk("vs_restart_addr", 32'(bus.DP_RAM_addr_in), 32'd0);
      frame_end();

      // Abort by reset at pixel 500
      fd0 = fd_cnt;
      w0  = wr_cnt;
      frame_start();
      for (int i = 0; i < 500; i++) send_pat(i);
      cyc(1'b0, 1'b0, 8'h00);
      rst = 1'b0;
      cyc(1'b0, 1'b1, 8'h55);
      cyc(1'b0, 1'b1, 8'hAA);
      chk("rst_abort_addr", 32'(bus.DP_RAM_addr_in), 32'd0);
      chk("rst_abort_data", 32'(bus.DP_RAM_data_in), 32'd0);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'($urandom));
      frame_end();
      chk("rst_abort_fd", 32'(fd_cnt - fd0), 32'd0);
      chk("rst_abort_wr", 32'(wr_cnt - w0), 32'd500);
      frame_start();
      send_pat(9);
      cyc(1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 8'h00);
      chk("rst_restart_addr", 32'(bus.DP_RAM_addr_in), 32'd0);
      frame_end();

      // Full frame
      fd0 = fd_cnt;
      w0  = wr_cnt;
      frame_start();
      send_lines(int'(YS));
      frame_end();
      chk("full_fd", 32'(fd_cnt - fd0), 32'd1);
      chk("full_wr", 32'(wr_cnt - w0), 32'(NPIX));
      chk("full_ovf", 32'(bus.overflow), 32'd0);
      chk("full_last_addr", 32'(bus.DP_RAM_addr_in), 32'h4AFF);

      // Overflow: one line too many
      fd0 = fd_cnt;
      w0  = wr_cnt;
      frame_start();
      send_lines(int'(YS) + 1);
      chk("ovf_set", 32'(bus.overflow), 32'd1);
      chk("ovf_wr", 32'(wr_cnt - w0), 32'(NPIX));
      chk("ovf_last_addr", 32'(bus.DP_RAM_addr_in), 32'h4AFF);
      frame_end();
      chk("ovf_sticky", 32'(bus.overflow), 32'd1);
      chk("ovf_fd", 32'(fd_cnt - fd0), 32'd1);
      frame_start();
      cyc(1'b0, 1'b0, 8'h00);
      chk("ovf_clear", 32'(bus.overflow), 32'd0);
      send_pat(3);
      cyc(1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 8'h00);
      chk("ovf_restart_addr", 32'(bus.DP_RAM_addr_in), 32'd0);
      frame_end();

      chk("q_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
